// File: rtl/v_alu_elem_sequencer.sv
// Element-group issue controller for the vector lane ALU: accepts one instruction,
// steps through LANES-wide element groups, stretches mul/div groups, pulses done/err.
module v_alu_elem_sequencer #(
  parameter int MAX_VL  = 64,
  parameter int LANES   = 4,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      instr_valid_i,
  output logic                      instr_ready_o,
  input  logic [4:0]                alu_op_i,
  input  logic [$clog2(MAX_VL):0]   vl_i,
  output logic                      issue_valid_o,
  input  logic                      issue_ready_i,
  output logic [4:0]                alu_op_o,
  output logic [$clog2(MAX_VL)-1:0] elem_idx_o,
  output logic [LANES-1:0]          elem_mask_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o
);

  localparam int VLW     = $clog2(MAX_VL) + 1;
  localparam int IW      = VLW - 1;
  localparam int LAT_MAX = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int CW      = $clog2(LAT_MAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          state;
  logic [VLW-1:0]  vl_q;
  logic [CW-1:0]   lat_q;
  logic [CW-1:0]   cnt_q;
  logic            err_q;

  logic [VLW-1:0]  vl_clamped;
  logic            legal;
  logic [CW-1:0]   lat_sel;
  logic            last_group;
  logic [IW-1:0]   next_idx;

  always_comb begin
    vl_clamped = (vl_i > VLW'(MAX_VL)) ? VLW'(MAX_VL) : vl_i;
    legal      = !(alu_op_i inside {5'd4, 5'd5, 5'd18, 5'd19, 5'd31});
    if (alu_op_i inside {[5'd13:5'd16]})
      lat_sel = CW'(DIV_LAT);
    else if (alu_op_i inside {[5'd9:5'd12], 5'd17})
      lat_sel = CW'(MUL_LAT);
    else
      lat_sel = CW'(1);
    last_group = ({1'b0, 1'b0, elem_idx_o} + (VLW+1)'(LANES)) >= {1'b0, vl_q};
    next_idx   = elem_idx_o + IW'(LANES);
  end

  always_comb begin
    elem_mask_o = '0;
    for (int unsigned k = 0; k < LANES; k++)
      elem_mask_o[k] = ({1'b0, 1'b0, elem_idx_o} + (VLW+1)'(k)) < {1'b0, vl_q};
  end

  always_comb begin
    instr_ready_o = (state == IDLE);
    issue_valid_o = (state == ISSUE);
    busy_o        = (state != IDLE);
    done_o        = (state == DONE);
    err_o         = (state == DONE) && err_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      vl_q       <= '0;
      lat_q      <= CW'(1);
      cnt_q      <= '0;
      err_q      <= 1'b0;
      alu_op_o   <= '0;
      elem_idx_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid_i) begin
            alu_op_o   <= alu_op_i;
            vl_q       <= vl_clamped;
            lat_q      <= lat_sel;
            err_q      <= !legal;
            elem_idx_o <= '0;
            state      <= (!legal || vl_clamped == '0) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          if (issue_ready_i) begin
            if (lat_q > CW'(1)) begin
              cnt_q <= lat_q - CW'(1);
              state <= WAIT;
            end else if (last_group) begin
              state <= DONE;
            end else begin
              elem_idx_o <= next_idx;
            end
          end
        end
        WAIT: begin
          if (cnt_q == CW'(1)) begin
            if (last_group) begin
              state <= DONE;
            end else begin
              elem_idx_o <= next_idx;
              state      <= ISSUE;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        DONE: begin
          err_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_v_alu_elem_sequencer.sv
// Directed bench for v_alu_elem_sequencer: a group-list scoreboard with cycle timing
// is checked every cycle, and each directed case pins its results with literals.
module tb_v_alu_elem_sequencer;
  localparam int MAX_VL  = 64;
  localparam int LANES   = 4;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 8;

  logic       clk = 1'b0;
  logic       rstn;
  logic       instr_valid_i;
  logic       instr_ready_o;
  logic [4:0] alu_op_i;
  logic [6:0] vl_i;
  logic       issue_valid_o;
  logic       issue_ready_i;
  logic [4:0] alu_op_o;
  logic [5:0] elem_idx_o;
  logic [3:0] elem_mask_o;
  logic       busy_o;
  logic       done_o;
  logic       err_o;

  always #5 clk = ~clk;

  v_alu_elem_sequencer #(
    .MAX_VL (MAX_VL),
    .LANES  (LANES),
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .instr_valid_i(instr_valid_i),
    .instr_ready_o(instr_ready_o),
    .alu_op_i     (alu_op_i),
    .vl_i         (vl_i),
    .issue_valid_o(issue_valid_o),
    .issue_ready_i(issue_ready_i),
    .alu_op_o     (alu_op_o),
    .elem_idx_o   (elem_idx_o),
    .elem_mask_o  (elem_mask_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lat_of(input int op);
    if (op >= 13 && op <= 16) return DIV_LAT;
    if ((op >= 9 && op <= 12) || op == 17) return MUL_LAT;
    return 1;
  endfunction

  function automatic bit illegal_op(input int op);
    return op == 4 || op == 5 || op == 18 || op == 19 || op == 31;
  endfunction

  typedef struct {int idx; int mask;} grp_t;
  grp_t q[$];

  // Scoreboard state for the instruction in flight
  bit active = 0;
  int cyc = 0;
  int last_op = 0;
  int cur_lat = 1;
  bit cur_err = 0;
  int next_cyc = 0;
  int done_cyc = 0;
  int acc_cyc = 0;
  int done_seen_cyc = 0;
  bit done_flag = 0;
  bit err_seen = 0;
  int hs_cnt = 0;
  int valid_cnt = 0;
  int hs_idx[64];
  int hs_mask[64];
  int hs_cyc[64];

  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      chk("rst_ready", instr_ready_o, 1);
      chk("rst_valid", issue_valid_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_alu_op", alu_op_o, 0);
      chk("rst_idx", elem_idx_o, 0);
      chk("rst_mask", elem_mask_o, 0);
      active = 0;
      q.delete();
      last_op = 0;
    end else begin
      bit exp_valid, exp_done;
      chk("instr_ready", instr_ready_o, !active);
      chk("busy", busy_o, active);
      chk("alu_op", alu_op_o, last_op);
      exp_valid = active && q.size() > 0 && cyc >= next_cyc;
      chk("issue_valid", issue_valid_o, exp_valid);
      if (issue_valid_o && q.size() > 0) begin
        chk("elem_idx", elem_idx_o, q[0].idx);
        chk("elem_mask", elem_mask_o, q[0].mask);
        valid_cnt++;
        if (issue_ready_i) begin
          if (hs_cnt < 64) begin
            hs_idx[hs_cnt]  = elem_idx_o;
            hs_mask[hs_cnt] = elem_mask_o;
            hs_cyc[hs_cnt]  = cyc;
          end
          hs_cnt++;
          void'(q.pop_front());
          next_cyc = cyc + cur_lat;
          if (q.size() == 0) done_cyc = cyc + cur_lat;
        end
      end
      exp_done = active && q.size() == 0 && cyc == done_cyc;
      chk("done", done_o, exp_done);
      chk("err", err_o, exp_done && cur_err);
      if (instr_valid_i && !active) begin
        int vle;
        active    = 1;
        last_op   = alu_op_i;
        cur_lat   = lat_of(alu_op_i);
        cur_err   = illegal_op(alu_op_i);
        acc_cyc   = cyc;
        next_cyc  = cyc + 1;
        done_cyc  = cyc + 1;
        hs_cnt    = 0;
        valid_cnt = 0;
        done_flag = 0;
        err_seen  = 0;
        vle = (vl_i > MAX_VL) ? MAX_VL : vl_i;
        q.delete();
        if (!cur_err) begin
          for (int i = 0; i < vle; i += LANES) begin
            grp_t g;
            g.idx  = i;
            g.mask = 0;
            for (int k = 0; k < LANES; k++)
              if (i + k < vle) g.mask |= (1 << k);
            q.push_back(g);
          end
        end
      end else if (done_o && active) begin
        active        = 0;
        done_flag     = 1;
        err_seen      = err_o;
        done_seen_cyc = cyc;
      end
    end
  end

  task automatic send(input int op, input int vl);
    @(posedge clk); #1;
    instr_valid_i = 1'b1;
    alu_op_i      = 5'(op);
    vl_i          = 7'(vl);
    @(posedge clk); #1;
    instr_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (!done_flag && n < limit) begin
      @(posedge clk);
      n++;
    end
    chk("done_within_budget", done_flag, 1);
  endtask

  initial begin
    rstn          = 1'b0;
    instr_valid_i = 1'b0;
    alu_op_i      = '0;
    vl_i          = '0;
    issue_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // add, vl=10: three consecutive groups, partial last mask
    send(0, 10);
    wait_done(50);
    chk("add_groups", hs_cnt, 3);
    chk("add_idx1", hs_idx[1], 4);
    chk("add_idx2", hs_idx[2], 8);
    chk("add_mask0", hs_mask[0], 4'b1111);
    chk("add_mask2", hs_mask[2], 4'b0011);
    chk("add_last_gap", hs_cyc[2] - acc_cyc, 3);
    chk("add_done_lat", done_seen_cyc - acc_cyc, 4);

    // divu, vl=8: groups 8 cycles apart; a request while busy is ignored
    send(13, 8);
    repeat (3) @(posedge clk);
    send(1, 4);
    wait_done(100);
    chk("div_groups", hs_cnt, 2);
    chk("div_first", hs_cyc[0] - acc_cyc, 1);
    chk("div_gap", hs_cyc[1] - hs_cyc[0], 8);
    chk("div_idx1", hs_idx[1], 4);
    chk("div_done_lat", done_seen_cyc - acc_cyc, 17);

    // sub, vl=4 with 5 stalled cycles
    @(posedge clk); #1 issue_ready_i = 1'b0;
    send(1, 4);
    repeat (5) @(posedge clk);
    #1 issue_ready_i = 1'b1;
    wait_done(50);
    chk("stall_valid_cycles", valid_cnt, 6);
    chk("stall_groups", hs_cnt, 1);
    chk("stall_hs_cyc", hs_cyc[0] - acc_cyc, 6);
    chk("stall_done_lat", done_seen_cyc - acc_cyc, 7);

    // illegal opcode 00100
    send(4, 16);
    wait_done(20);
    chk("illegal_groups", hs_cnt, 0);
    chk("illegal_err", err_seen, 1);
    chk("illegal_done_lat", done_seen_cyc - acc_cyc, 1);

    // vl=0
    send(0, 0);
    wait_done(20);
    chk("vl0_groups", hs_cnt, 0);
    chk("vl0_err", err_seen, 0);
    chk("vl0_done_lat", done_seen_cyc - acc_cyc, 1);

    // 200 truncates to 72 on the 7-bit port, still above MAX_VL -> 64
    send(0, 200);
    wait_done(100);
    chk("clamp_groups", hs_cnt, 16);
    chk("clamp_last_idx", hs_idx[15], 60);
    chk("clamp_last_mask", hs_mask[15], 4'b1111);
    chk("clamp_done_lat", done_seen_cyc - acc_cyc, 17);

    // mulu, vl=6: 2-cycle groups
    send(9, 6);
    wait_done(50);
    chk("mul_groups", hs_cnt, 2);
    chk("mul_gap", hs_cyc[1] - hs_cyc[0], 2);
    chk("mul_mask1", hs_mask[1], 4'b0011);
    chk("mul_done_lat", done_seen_cyc - acc_cyc, 5);

    // reset in the middle of a long division, then a normal instruction
    send(13, 64);
    repeat (12) @(posedge clk);
    #1 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    chk("abort_no_done", done_flag, 0);
    send(0, 5);
    wait_done(50);
    chk("post_rst_groups", hs_cnt, 2);
    chk("post_rst_idx0", hs_idx[0], 0);
    chk("post_rst_mask1", hs_mask[1], 4'b0001);
    chk("post_rst_done_lat", done_seen_cyc - acc_cyc, 3);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
